// File: rtl/mul_div_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mul_div_unit: 34-cycle shift-add multiply / restoring divide, HI/LO regs |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module mul_div_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  input  logic        hi_we_i,
  input  logic        lo_we_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        div_zero_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  localparam logic [4:0] LAST_ITER = 5'd31;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic        is_div_q;
  logic        neg_q;
  logic        rneg_q;
  logic [31:0] b_q;
  logic [31:0] src1_q;
  logic [63:0] acc_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        busy_q;
  logic        done_q;
  logic        dz_q;

  logic        is_signed;
  logic        start_div;
  logic        s1_neg;
  logic        s2_neg;
  logic [31:0] mag1;
  logic [31:0] mag2;
  logic [32:0] add_sum;
  logic [32:0] rem_shift;
  logic [31:0] rem_diff;
  logic [63:0] acc_d;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] hi_d;
  logic [31:0] lo_d;

  // Operand conditioning at acceptance: signed ops work on magnitudes.
  always_comb begin
    is_signed = ~op_i[0];
    start_div = op_i[1];
    s1_neg    = is_signed & src1_i[31];
    s2_neg    = is_signed & src2_i[31];
    mag1      = s1_neg ? (~src1_i + 32'd1) : src1_i;
    mag2      = s2_neg ? (~src2_i + 32'd1) : src2_i;
  end

  // One iteration: multiply keeps {partial product, multiplier} in acc,
  // divide keeps {partial remainder, dividend/quotient} in acc.
  always_comb begin
    add_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    rem_shift = {acc_q[63:32], acc_q[31]};
    rem_diff  = rem_shift[31:0] - b_q;
    acc_d     = {add_sum, acc_q[31:1]};
    if (is_div_q) begin
      if (rem_shift >= {1'b0, b_q}) begin
        acc_d = {rem_diff, acc_q[30:0], 1'b1};
      end else begin
        acc_d = {rem_shift[31:0], acc_q[30:0], 1'b0};
      end
    end
  end

  always_comb begin
    prod_fix = neg_q  ? (~acc_q + 64'd1) : acc_q;
    quo_fix  = neg_q  ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    rem_fix  = rneg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
    hi_d     = prod_fix[63:32];
    lo_d     = prod_fix[31:0];
    if (is_div_q) begin
      if (b_q == 32'd0) begin
        hi_d = src1_q;
        lo_d = 32'hFFFF_FFFF;
      end else begin
        hi_d = rem_fix;
        lo_d = quo_fix;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      b_q      <= 32'd0;
      src1_q   <= 32'd0;
      acc_q    <= 64'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q  <= S_CALC;
            busy_q   <= 1'b1;
            cnt_q    <= 5'd0;
            is_div_q <= start_div;
            neg_q    <= s1_neg ^ s2_neg;
            rneg_q   <= start_div & s1_neg;
            src1_q   <= src1_i;
            b_q      <= start_div ? mag2 : mag1;
            acc_q    <= {32'd0, start_div ? mag1 : mag2};
          end else begin
            if (hi_we_i) hi_q <= wdata_i;
            if (lo_we_i) lo_q <= wdata_i;
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == LAST_ITER) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          done_q  <= 1'b1;
          dz_q    <= is_div_q & (b_q == 32'd0);
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign div_zero_o = dz_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule
`default_nettype wire

// File: doc/mul_div_unit.md
# mul_div_unit

Multi-cycle integer multiply/divide unit for the EX stage. It sits beside the combinational ALU and is fed by the same register-file operand pair, `src1_i` (rs) and `src2_i` (rt). It holds the architectural HI/LO registers, which drive the write-back result mux for mfhi/mflo. The pipeline/controller starts an operation with a one-cycle `start_i` pulse and stalls on `busy_o`.

## Interface
- Parameters: none; datapath fixed at 32 bits, HI/LO 32 bits each.
- clk_i  input  1  rising-edge clock
- rst_i  input  1  synchronous, active-high reset
- start_i  input  1  start request; accepted only when `busy_o`=0
- op_i  input  2  operation select, sampled with `start_i`: 00 mult, 01 multu, 10 div, 11 divu
- src1_i  input  32  rs operand (multiplicand / dividend), sampled with `start_i`
- src2_i  input  32  rt operand (multiplier / divisor), sampled with `start_i`
- hi_we_i  input  1  mthi write enable
- lo_we_i  input  1  mtlo write enable
- wdata_i  input  32  mthi/mtlo data
- busy_o  output  1  operation in progress
- done_o  output  1  one-cycle pulse; HI/LO hold the new result
- div_zero_o  output  1  one-cycle pulse together with `done_o` when a div/divu had divisor 0
- hi_o  output  32  HI register
- lo_o  output  32  LO register

## Operation
- FSM states:
  - IDLE: `start_i`=1 → latch operands and op, take magnitudes if signed, clear the 5-bit counter, go to CALC.
  - CALC: exactly 32 iterations, one per cycle, counter 0..31; at count 31 go to FIX.
  - FIX: apply sign correction, write HI/LO, go to IDLE with `done_o`=1.
- Multiply: shift-add on magnitudes into a 64-bit accumulator.
  - mult negates the 64-bit product when the operand signs differ.
  - HI = product[63:32], LO = product[31:0].
- Divide: restoring division on magnitudes, producing quotient and remainder.
  - Signed quotient is negated when the signs differ; signed remainder takes the sign of the dividend.
  - LO = quotient, HI = remainder.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (truncated natural result); no flag.
- Divide by zero: full latency still applies. Result is LO=0xFFFFFFFF, HI=src1_i (the original dividend, unsigned or signed); `div_zero_o`=1 with `done_o`.
- mthi/mtlo: in IDLE, with `start_i`=0, `hi_we_i`/`lo_we_i` load `wdata_i` into HI/LO at the clock edge. Both may be asserted in the same cycle.
- Requests ignored, with no effect on state:
  - `start_i` while busy.
  - `hi_we_i`/`lo_we_i` while busy.
  - `hi_we_i`/`lo_we_i` in the same cycle as an accepted `start_i`; the start wins.
- `hi_o`/`lo_o` change only in FIX, on an mthi/mtlo write, or on reset. They keep the previous result throughout CALC.

## Timing
- Reset (any state, including mid-CALC) forces IDLE, clears the counter, and sets busy_o=0, done_o=0, div_zero_o=0, hi_o=0, lo_o=0. The aborted operation produces no result.
- Let `start_i` be accepted at the edge ending cycle 0:
  - Cycles 1–32: CALC, `busy_o`=1.
  - Cycle 33: FIX, `busy_o`=1.
  - Cycle 34: `busy_o`=0, `done_o`=1, new HI/LO visible.
  - Total latency is 34 cycles, independent of operand values.
- A new `start_i` is accepted in cycle 34, so the back-to-back issue interval is 34 cycles.
- `busy_o` is a registered output derived from state (CALC or FIX). `done_o` and `div_zero_o` are registered and high for exactly one cycle.
- Operands and `op_i` are sampled only at acceptance; later changes to them during CALC have no effect.
- mthi/mtlo are visible on `hi_o`/`lo_o` in the cycle after the write edge.

## Test plan
- multu 0xFFFFFFFF × 0xFFFFFFFF → after 34 cycles HI=0xFFFFFFFE, LO=0x00000001, `done_o` a single pulse.
- mult 0xFFFFFFFD (−3) × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB; then div −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu 0x12345678 / 0 → LO=0xFFFFFFFF, HI=0x12345678, `div_zero_o`=1 in the same cycle as `done_o`; div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0, `div_zero_o`=0.
- Start multu 5×6, pulse `start_i` with different operands at cycle 10 and assert `hi_we_i` at cycle 12 → both ignored; result HI=0, LO=30 at cycle 34.
- Start divu, assert `rst_i` at cycle 15 → next cycle busy_o=0, hi_o=lo_o=0, and no `done_o` ever pulses; a fresh start afterwards completes normally.
- In IDLE, `hi_we_i`=`lo_we_i`=1 with `wdata_i`=0xCAFEF00D → both registers read 0xCAFEF00D next cycle; repeat with `start_i`=1 in the same cycle → write dropped, operation runs.
